// File: rtl/sme_match_collector_pkg.sv
// Shared types and constants for the SME match collector: rule ID width,
// the null rule ID, FSM states and the per-packet summary word layout.
package sme_pkg;

    localparam int RULE_ID_W = 32;
    localparam logic [RULE_ID_W-1:0] NULL_RULE_ID = 32'd0;

    // Per-packet count needs to reach 64 when MAX_MATCHES is at its limit.
    localparam int CUR_CNT_W = 7;

    typedef struct packed {
        logic       ovf;
        logic       rsvd;
        logic [5:0] cnt;
    } sme_sum_t;

    localparam int SUM_W = $bits(sme_sum_t);

    typedef enum logic {
        COLLECT = 1'b0,
        DISCARD = 1'b1
    } sme_state_e;

    function automatic sme_sum_t make_sum(input logic ovf, input logic [CUR_CNT_W-1:0] cnt);
        sme_sum_t s;
        s.ovf  = ovf;
        s.rsvd = 1'b0;
        s.cnt  = cnt[5:0];
        return s;
    endfunction

endpackage

// File: rtl/sme_match_collector_if.sv
// Bundle of the match input stream, the two drain ports and the statistics.
// The slave side is the collector; the master side is the wrapper plus core.
interface sme_match_collector_if;
    import sme_pkg::*;

    logic [RULE_ID_W-1:0] match_rules_ID;
    logic                 match_last;
    logic                 match_valid;
    logic                 match_release;

    logic [RULE_ID_W-1:0] m_id_data;
    logic                 m_id_valid;
    logic                 m_id_ready;

    logic [SUM_W-1:0]     m_sum_data;
    logic                 m_sum_valid;
    logic                 m_sum_ready;

    logic [31:0]          pkt_cnt;
    logic [31:0]          drop_cnt;

    modport slave (
        input  match_rules_ID, match_last, match_valid, m_id_ready, m_sum_ready,
        output match_release, m_id_data, m_id_valid, m_sum_data, m_sum_valid,
        output pkt_cnt, drop_cnt
    );

    modport master (
        output match_rules_ID, match_last, match_valid, m_id_ready, m_sum_ready,
        input  match_release, m_id_data, m_id_valid, m_sum_data, m_sum_valid,
        input  pkt_cnt, drop_cnt
    );

endinterface

// File: rtl/sme_match_collector_sync_fifo.sv
// First-word fall-through synchronous FIFO with registered full/empty flags.
// DEPTH must be a power of two and at least 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO or a pop from an empty one is dropped.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: every variable gets a default at the top of an always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: the storage array has no reset; entries are only observed behind empty, and a resettable array cannot map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/sme_match_collector.sv
// Collects rule IDs per packet from the SME wrapper, keeps the first MAX_MATCHES
// non-null IDs and emits one {ovf, 0, count} summary per packet for the core.
module sme_match_collector
    import sme_pkg::*;
#(
    parameter int MAX_MATCHES = 16,
    parameter int ID_DEPTH    = 32,
    parameter int SUM_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sme_match_collector_if.slave bus
);

    localparam logic [CUR_CNT_W-1:0] CAP = CUR_CNT_W'(MAX_MATCHES);

    sme_state_e           state;
    logic [CUR_CNT_W-1:0] cur_cnt;
    logic                 ovf;
    logic                 ready_q;
    logic [31:0]          pkt_cnt_q;
    logic [31:0]          drop_cnt_q;

    logic                 id_full;
    logic                 id_empty;
    logic                 sum_full;
    logic                 sum_empty;
    logic [SUM_W-1:0]     sum_head;

    logic                 release_w;
    logic                 accept;
    logic                 is_id;
    logic                 at_cap;
    logic                 id_push;
    logic                 drop;
    logic                 sum_push;
    logic [CUR_CNT_W-1:0] cnt_final;
    logic                 ovf_final;
    sme_sum_t             sum_word;

    // Release comes from registers only; ready_q holds it low until the first edge out of reset.
    assign release_w = ready_q && !id_full && !sum_full;

    always_comb begin
        accept    = bus.match_valid && release_w;
        is_id     = (bus.match_rules_ID != NULL_RULE_ID);
        at_cap    = (cur_cnt == CAP);
        id_push   = accept && is_id && (state == COLLECT) && !at_cap;
        drop      = accept && is_id && ((state == DISCARD) || at_cap);
        sum_push  = accept && bus.match_last;
        cnt_final = cur_cnt + CUR_CNT_W'(id_push);
        ovf_final = ovf || drop;
        sum_word  = make_sum(ovf_final, cnt_final);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            cur_cnt    <= '0;
            ovf        <= 1'b0;
            ready_q    <= 1'b0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            ready_q <= 1'b1;
            if (sum_push) pkt_cnt_q  <= pkt_cnt_q + 32'd1;
            if (drop)     drop_cnt_q <= drop_cnt_q + 32'd1;
            if (accept) begin
                if (bus.match_last) begin
                    state   <= COLLECT;
                    cur_cnt <= '0;
                    ovf     <= 1'b0;
                end else begin
                    cur_cnt <= cnt_final;
                    ovf     <= ovf_final;
                    if (drop) state <= DISCARD;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (RULE_ID_W),
        .DEPTH (ID_DEPTH)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (id_push),
        .push_data (bus.match_rules_ID),
        .pop       (bus.m_id_ready),
        .head      (bus.m_id_data),
        .full      (id_full),
        .empty     (id_empty)
    );

    sync_fifo #(
        .WIDTH (SUM_W),
        .DEPTH (SUM_DEPTH)
    ) u_sum_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (sum_push),
        .push_data (sum_word),
        .pop       (bus.m_sum_ready),
        .head      (sum_head),
        .full      (sum_full),
        .empty     (sum_empty)
    );

    assign bus.match_release = release_w;
    assign bus.m_id_valid    = !id_empty;
    assign bus.m_sum_valid   = !sum_empty;
    assign bus.m_sum_data    = sum_head;
    assign bus.pkt_cnt       = pkt_cnt_q;
    assign bus.drop_cnt      = drop_cnt_q;

    // DISCARD is only reachable once the packet has filled its quota.
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cur_cnt <= CAP);
    a_discard_cap: assert property (@(posedge clk) disable iff (!rst_n)
        (state == DISCARD) |-> (cur_cnt == CAP));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(id_push && id_full) && !(sum_push && sum_full));

endmodule

// File: tb/tb_sme_match_collector.sv
// Bench for sme_match_collector: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_sme_match_collector;
    import sme_pkg::*;

    localparam int MAXM = 16;
    localparam int IDD  = 32;
    localparam int SUMD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sme_match_collector_if bus ();

    sme_match_collector #(
        .MAX_MATCHES (MAXM),
        .ID_DEPTH    (IDD),
        .SUM_DEPTH   (SUMD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as queues, per-packet stored count and overflow.
    bit [31:0] m_ids[$];
    bit [7:0]  m_sums[$];
    int        m_stored;
    bit        m_ovf;
    bit        m_armed;
    bit [31:0] m_pkt;
    bit [31:0] m_drop;

    bit [31:0] got_ids[$];
    bit [7:0]  got_sums[$];
    bit [31:0] exp_ids[$];
    bit [7:0]  exp_sums[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit m_release();
        return m_armed && (m_ids.size() < IDD) && (m_sums.size() < SUMD);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ids.delete();
                m_sums.delete();
                m_stored = 0;
                m_ovf    = 1'b0;
                m_armed  = 1'b0;
                m_pkt    = '0;
                m_drop   = '0;
            end else begin
                bit acc;
                acc = bus.match_valid && m_release();
                if (bus.m_id_ready && m_ids.size() > 0) void'(m_ids.pop_front());
                if (bus.m_sum_ready && m_sums.size() > 0) void'(m_sums.pop_front());
                if (acc) begin
                    if (bus.match_rules_ID != 32'd0) begin
                        if (m_stored < MAXM) begin
                            m_ids.push_back(bus.match_rules_ID);
                            m_stored++;
                        end else begin
                            m_drop++;
                            m_ovf = 1'b1;
                        end
                    end
                    if (bus.match_last) begin
                        m_sums.push_back({m_ovf, 1'b0, 6'(m_stored)});
                        m_pkt++;
                        m_stored = 0;
                        m_ovf    = 1'b0;
                    end
                end
                m_armed = 1'b1;
            end
        end
    end

    // Log what the core side actually popped.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) begin
                if (bus.m_id_ready && bus.m_id_valid) got_ids.push_back(bus.m_id_data);
                if (bus.m_sum_ready && bus.m_sum_valid) got_sums.push_back(bus.m_sum_data);
            end
        end
    end

    always @(negedge clk) begin
        check("release", bus.match_release, m_release());
        check("id_valid", bus.m_id_valid, m_ids.size() != 0);
        if (m_ids.size() != 0) check("id_data", bus.m_id_data, m_ids[0]);
        check("sum_valid", bus.m_sum_valid, m_sums.size() != 0);
        if (m_sums.size() != 0) check("sum_data", bus.m_sum_data, m_sums[0]);
        check("pkt_cnt", bus.pkt_cnt, m_pkt);
        check("drop_cnt", bus.drop_cnt, m_drop);
    end

    // All tasks below start and end just after a falling edge.
    task automatic send_beat(input logic [31:0] id, input logic last);
        int budget;
        budget = 500;
        bus.match_rules_ID = id;
        bus.match_last     = last;
        bus.match_valid    = 1'b1;
        while (!bus.match_release && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout id=%0d release=0 required=1 within 500 cycles", id);
        end
        @(negedge clk);
        bus.match_valid = 1'b0;
        bus.match_last  = 1'b0;
    endtask

    task automatic do_reset();
        bus.match_valid = 1'b0;
        bus.match_last  = 1'b0;
        bus.m_id_ready  = 1'b0;
        bus.m_sum_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        got_ids.delete();
        got_sums.delete();
        exp_ids.delete();
        exp_sums.delete();
    endtask

    task automatic drain();
        bus.m_id_ready  = 1'b1;
        bus.m_sum_ready = 1'b1;
        repeat (80) @(negedge clk);
        bus.m_id_ready  = 1'b0;
        bus.m_sum_ready = 1'b0;
    endtask

    task automatic compare_logs(input string name);
        check({name, "_n_ids"}, 64'(got_ids.size()), 64'(exp_ids.size()));
        for (int i = 0; i < got_ids.size() && i < exp_ids.size(); i++)
            check({name, "_id"}, got_ids[i], exp_ids[i]);
        check({name, "_n_sums"}, 64'(got_sums.size()), 64'(exp_sums.size()));
        for (int i = 0; i < got_sums.size() && i < exp_sums.size(); i++)
            check({name, "_sum"}, got_sums[i], exp_sums[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rdy_pct;
        bus.match_rules_ID = '0;
        bus.match_valid    = 1'b0;
        bus.match_last     = 1'b0;
        bus.m_id_ready     = 1'b0;
        bus.m_sum_ready    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_release", bus.match_release, 1'b0);
        check("rst_id_valid", bus.m_id_valid, 1'b0);
        check("rst_sum_valid", bus.m_sum_valid, 1'b0);
        check("rst_pkt_cnt", bus.pkt_cnt, 32'd0);
        check("rst_drop_cnt", bus.drop_cnt, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("release_after_reset", bus.match_release, 1'b1);

        // Three IDs in one packet.
        do_reset();
        bus.m_id_ready  = 1'b1;
        bus.m_sum_ready = 1'b1;
        send_beat(32'd5, 1'b0);
        send_beat(32'd9, 1'b0);
        send_beat(32'd12, 1'b1);
        drain();
        exp_ids  = '{32'd5, 32'd9, 32'd12};
        exp_sums = '{8'h03};
        compare_logs("three_ids");
        check("three_pkt", bus.pkt_cnt, 32'd1);
        check("three_drop", bus.drop_cnt, 32'd0);

        // Null-only packet.
        do_reset();
        send_beat(32'd0, 1'b1);
        drain();
        exp_sums = '{8'h00};
        compare_logs("null_pkt");
        check("null_pkt_cnt", bus.pkt_cnt, 32'd1);
        check("null_drop", bus.drop_cnt, 32'd0);

        // Overflowing packet, then a short one.
        do_reset();
        for (int i = 1; i <= 20; i++) send_beat(32'(i), i == 20);
        send_beat(32'd7, 1'b1);
        drain();
        for (int i = 1; i <= 16; i++) exp_ids.push_back(32'(i));
        exp_ids.push_back(32'd7);
        exp_sums = '{8'h90, 8'h01};
        compare_logs("overflow");
        check("overflow_drop", bus.drop_cnt, 32'd4);
        check("overflow_pkt", bus.pkt_cnt, 32'd2);

        // Summary FIFO fills with sinks stalled; one pop lets the ninth packet in.
        do_reset();
        for (int i = 0; i < 8; i++) send_beat(32'(100 + i), 1'b1);
        fork
            send_beat(32'd108, 1'b1);
            begin
                @(negedge clk);
                check("sum_full_release", bus.match_release, 1'b0);
                bus.m_sum_ready = 1'b1;
                @(negedge clk);
                bus.m_sum_ready = 1'b0;
                check("sum_pop_release", bus.match_release, 1'b1);
            end
        join
        drain();
        for (int i = 0; i < 9; i++) begin
            exp_ids.push_back(32'(100 + i));
            exp_sums.push_back(8'h01);
        end
        compare_logs("sum_full");
        check("sum_full_pkt", bus.pkt_cnt, 32'd9);

        // ID FIFO full, pop while the next beat waits.
        do_reset();
        for (int i = 1; i <= 16; i++) send_beat(32'(200 + i), i == 16);
        for (int i = 1; i <= 16; i++) send_beat(32'(300 + i), i == 16);
        fork
            send_beat(32'd400, 1'b1);
            begin
                @(negedge clk);
                check("id_full_release", bus.match_release, 1'b0);
                bus.m_id_ready = 1'b1;
                @(negedge clk);
                bus.m_id_ready = 1'b0;
            end
        join
        drain();
        for (int i = 1; i <= 16; i++) exp_ids.push_back(32'(200 + i));
        for (int i = 1; i <= 16; i++) exp_ids.push_back(32'(300 + i));
        exp_ids.push_back(32'd400);
        exp_sums = '{8'h10, 8'h10, 8'h01};
        compare_logs("id_full");

        // Reset in the middle of a packet.
        do_reset();
        send_beat(32'd5, 1'b0);
        send_beat(32'd6, 1'b0);
        send_beat(32'd7, 1'b0);
        do_reset();
        check("midrst_id_valid", bus.m_id_valid, 1'b0);
        check("midrst_sum_valid", bus.m_sum_valid, 1'b0);
        check("midrst_pkt", bus.pkt_cnt, 32'd0);
        check("midrst_drop", bus.drop_cnt, 32'd0);
        send_beat(32'd42, 1'b1);
        drain();
        exp_ids  = '{32'd42};
        exp_sums = '{8'h01};
        compare_logs("mid_reset");

        // Random traffic with varying sink pressure.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            case ((c / 300) % 3)
                0:       rdy_pct = 90;
                1:       rdy_pct = 30;
                default: rdy_pct = 0;
            endcase
            bus.match_valid    = ($urandom_range(0, 3) != 0);
            bus.match_rules_ID = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            bus.match_last     = ($urandom_range(0, 19) == 0);
            bus.m_id_ready     = ($urandom_range(0, 99) < rdy_pct);
            bus.m_sum_ready    = ($urandom_range(0, 99) < rdy_pct);
            @(negedge clk);
        end
        bus.match_valid = 1'b0;
        bus.match_last  = 1'b0;
        drain();
        check("final_id_empty", bus.m_id_valid, 1'b0);
        check("final_sum_empty", bus.m_sum_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
